// File: rtl/rob_retire_module.sv
// In-order ROB retirement tracker: records allocated ids, collects EXU completions and
// retires up to RET_WIDTH oldest finished entries per cycle back to the id allocator.
module rob_retire_module #(
    parameter int unsigned ROB_ID_WIDTH = 8,
    parameter int unsigned ROB_DEPTH    = 128,
    parameter int unsigned RET_WIDTH    = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [RET_WIDTH-1:0]    i_alloc_vld,
    input  logic [ROB_ID_WIDTH-1:0] i_alloc_base_id,
    input  logic [RET_WIDTH-1:0]    i_alloc_ld,
    input  logic [RET_WIDTH-1:0]    i_alloc_st,
    input  logic                    i_cmt0_vld,
    input  logic [ROB_ID_WIDTH-1:0] i_cmt0_rob_id,
    input  logic                    i_cmt0_excp,
    input  logic                    i_cmt1_vld,
    input  logic [ROB_ID_WIDTH-1:0] i_cmt1_rob_id,
    input  logic                    i_cmt1_excp,
    input  logic                    i_flush,
    input  logic [ROB_ID_WIDTH-1:0] i_flush_rob_id,
    input  logic                    i_trap_flush,
    output logic [RET_WIDTH-1:0]    o_ret_vld,
    output logic [RET_WIDTH-1:0]    o_ret_ld_vld,
    output logic [RET_WIDTH-1:0]    o_ret_st_vld,
    output logic [ROB_ID_WIDTH-1:0] o_ret_base_id,
    output logic                    o_s_ret,
    output logic                    o_excp_vld,
    output logic [ROB_ID_WIDTH-1:0] o_excp_rob_id,
    output logic [ROB_ID_WIDTH-1:0] o_head_id
);
    localparam int unsigned IDX_W = ROB_ID_WIDTH - 1;

    typedef logic [ROB_ID_WIDTH-1:0] rob_id_t;
    typedef logic [IDX_W-1:0]        rob_idx_t;

    // a is older than b; the wrap bit disambiguates index comparison across the wrap.
    function automatic logic is_older(input rob_id_t a, input rob_id_t b);
        if (a[IDX_W] ^ b[IDX_W]) begin
            return a[IDX_W-1:0] >= b[IDX_W-1:0];
        end
        return a[IDX_W-1:0] < b[IDX_W-1:0];
    endfunction

    // Full id of a live entry: indices at or past the head share its wrap bit.
    function automatic rob_id_t entry_id(input rob_idx_t idx, input rob_id_t head);
        logic wrap;
        wrap = (idx >= head[IDX_W-1:0]) ? head[IDX_W] : ~head[IDX_W];
        return {wrap, idx};
    endfunction

    logic [ROB_DEPTH-1:0] vld_q, done_q, excp_q, ld_q, st_q;
    logic [ROB_DEPTH-1:0] vld_d, done_d, excp_d, ld_d, st_d;
    rob_id_t              head_q;
    logic                 excp_pend_q;

    logic [RET_WIDTH-1:0][ROB_ID_WIDTH-1:0] lane_id;
    rob_idx_t                               lane_idx;
    logic                                   lane_ok;
    logic                                   chain;
    logic [RET_WIDTH-1:0]                   lane_ld, lane_st, sel;
    rob_id_t                                ret_cnt;

    rob_idx_t cmt0_idx, cmt1_idx;
    logic     cmt0_hit, cmt1_hit;
    rob_id_t  alloc_id;
    rob_idx_t alloc_idx;
    logic     alloc_bad;
    rob_idx_t head_idx;
    logic     excp_cond;

    assign cmt0_idx = i_cmt0_rob_id[IDX_W-1:0];
    assign cmt1_idx = i_cmt1_rob_id[IDX_W-1:0];
    assign cmt0_hit = i_cmt0_vld & vld_q[cmt0_idx] & (entry_id(cmt0_idx, head_q) == i_cmt0_rob_id);
    assign cmt1_hit = i_cmt1_vld & vld_q[cmt1_idx] & (entry_id(cmt1_idx, head_q) == i_cmt1_rob_id);

    assign head_idx  = head_q[IDX_W-1:0];
    assign excp_cond = ~i_trap_flush & vld_q[head_idx] & done_q[head_idx] & excp_q[head_idx];

    // Retire lanes form a prefix: a lane survives only if every older lane also retires.
    always_comb begin
        lane_id  = '0;
        lane_idx = '0;
        lane_ok  = 1'b0;
        lane_ld  = '0;
        lane_st  = '0;
        sel      = '0;
        ret_cnt  = '0;
        chain    = 1'b1;
        for (int unsigned k = 0; k < RET_WIDTH; k++) begin
            lane_id[k] = head_q + rob_id_t'(k);
            lane_idx   = lane_id[k][IDX_W-1:0];
            lane_ld[k] = ld_q[lane_idx];
            lane_st[k] = st_q[lane_idx];
            lane_ok    = vld_q[lane_idx] & done_q[lane_idx] & ~excp_q[lane_idx]
                         & ~(i_flush & is_older(i_flush_rob_id, lane_id[k]));
            chain      = chain & lane_ok;
            sel[k]     = chain & ~i_trap_flush;
            ret_cnt    = ret_cnt + rob_id_t'(sel[k]);
        end
    end

    always_comb begin
        vld_d     = vld_q;
        done_d    = done_q;
        excp_d    = excp_q;
        ld_d      = ld_q;
        st_d      = st_q;
        alloc_id  = '0;
        alloc_idx = '0;
        alloc_bad = 1'b0;

        for (int unsigned k = 0; k < RET_WIDTH; k++) begin
            if (sel[k]) begin
                vld_d[lane_id[k][IDX_W-1:0]] = 1'b0;
            end
        end

        if (cmt0_hit) begin
            done_d[cmt0_idx] = 1'b1;
            excp_d[cmt0_idx] = excp_d[cmt0_idx] | i_cmt0_excp;
        end
        if (cmt1_hit) begin
            done_d[cmt1_idx] = 1'b1;
            excp_d[cmt1_idx] = excp_d[cmt1_idx] | i_cmt1_excp;
        end

        if (i_trap_flush) begin
            vld_d = '0;
        end else if (i_flush) begin
            for (int unsigned i = 0; i < ROB_DEPTH; i++) begin
                if (is_older(i_flush_rob_id, entry_id(rob_idx_t'(i), head_q))) begin
                    vld_d[i] = 1'b0;
                end
            end
        end

        for (int unsigned k = 0; k < RET_WIDTH; k++) begin
            alloc_id  = i_alloc_base_id + rob_id_t'(k);
            alloc_idx = alloc_id[IDX_W-1:0];
            if (i_alloc_vld[k]) begin
                alloc_bad = alloc_bad | vld_q[alloc_idx] | is_older(alloc_id, head_q);
                if (!i_flush && !i_trap_flush) begin
                    vld_d[alloc_idx]  = 1'b1;
                    done_d[alloc_idx] = 1'b0;
                    excp_d[alloc_idx] = 1'b0;
                    ld_d[alloc_idx]   = i_alloc_ld[k];
                    st_d[alloc_idx]   = i_alloc_st[k];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q         <= '0;
            done_q        <= '0;
            excp_q        <= '0;
            ld_q          <= '0;
            st_q          <= '0;
            head_q        <= '0;
            excp_pend_q   <= 1'b0;
            o_ret_vld     <= '0;
            o_ret_ld_vld  <= '0;
            o_ret_st_vld  <= '0;
            o_ret_base_id <= '0;
            o_s_ret       <= 1'b0;
            o_excp_vld    <= 1'b0;
            o_excp_rob_id <= '0;
        end else begin
            vld_q         <= vld_d;
            done_q        <= done_d;
            excp_q        <= excp_d;
            ld_q          <= ld_d;
            st_q          <= st_d;
            head_q        <= head_q + ret_cnt;
            o_ret_vld     <= sel;
            o_ret_ld_vld  <= sel & lane_ld;
            o_ret_st_vld  <= sel & lane_st;
            o_ret_base_id <= head_q;
            o_s_ret       <= |(sel & lane_st);
            // Excepting head stalls, so report it once per stall episode.
            excp_pend_q   <= excp_cond;
            o_excp_vld    <= excp_cond & ~excp_pend_q;
            o_excp_rob_id <= (excp_cond & ~excp_pend_q) ? head_q : '0;
        end
    end

    assign o_head_id = head_q;

    a_alloc_free: assert property (@(posedge clk) disable iff (rst)
        !(alloc_bad && !i_flush && !i_trap_flush))
        else $error("allocation targets a live or already-retired ROB id");

endmodule

// File: tb/tb_rob_retire_module.sv
// Randomized and directed scoreboard bench for rob_retire_module against an in-order
// queue model of the reorder buffer.
module tb_rob_retire_module;
    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [3:0] i_alloc_vld, i_alloc_ld, i_alloc_st;
    logic [7:0] i_alloc_base_id;
    logic       i_cmt0_vld, i_cmt0_excp, i_cmt1_vld, i_cmt1_excp;
    logic [7:0] i_cmt0_rob_id, i_cmt1_rob_id;
    logic       i_flush, i_trap_flush;
    logic [7:0] i_flush_rob_id;
    logic [3:0] o_ret_vld, o_ret_ld_vld, o_ret_st_vld;
    logic [7:0] o_ret_base_id, o_excp_rob_id, o_head_id;
    logic       o_s_ret, o_excp_vld;

    rob_retire_module #(.ROB_ID_WIDTH(8), .ROB_DEPTH(128), .RET_WIDTH(4)) dut (
        .clk(clk), .rst(rst),
        .i_alloc_vld(i_alloc_vld), .i_alloc_base_id(i_alloc_base_id),
        .i_alloc_ld(i_alloc_ld), .i_alloc_st(i_alloc_st),
        .i_cmt0_vld(i_cmt0_vld), .i_cmt0_rob_id(i_cmt0_rob_id), .i_cmt0_excp(i_cmt0_excp),
        .i_cmt1_vld(i_cmt1_vld), .i_cmt1_rob_id(i_cmt1_rob_id), .i_cmt1_excp(i_cmt1_excp),
        .i_flush(i_flush), .i_flush_rob_id(i_flush_rob_id), .i_trap_flush(i_trap_flush),
        .o_ret_vld(o_ret_vld), .o_ret_ld_vld(o_ret_ld_vld), .o_ret_st_vld(o_ret_st_vld),
        .o_ret_base_id(o_ret_base_id), .o_s_ret(o_s_ret),
        .o_excp_vld(o_excp_vld), .o_excp_rob_id(o_excp_rob_id), .o_head_id(o_head_id)
    );

    typedef struct { logic [7:0] id; bit done; bit excp; bit ld; bit st; } ent_t;
    typedef struct { int cyc; logic [3:0] ret; logic [3:0] ld; logic [3:0] st;
                     logic [7:0] base; bit excp; logic [7:0] excp_id; } ev_t;
    typedef struct { int cyc; logic [7:0] head; } hd_t;

    ent_t       rob[$];
    ev_t        ev_q[$];
    hd_t        hd_q[$];
    logic [7:0] mhead, next_alloc;
    bit         prev_cond;
    bit         mon_en = 1'b0;
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;
    ev_t        me;
    hd_t        mh;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic bit younger(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] d;
        d = a - b;
        return (d != 8'd0) && (d < 8'd128);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Drive one cycle of stimulus, advance the reference model and queue its predictions.
    task automatic step(input bit r, input int na, input logic [3:0] ldm, input logic [3:0] stm,
                        input bit c0v, input logic [7:0] c0id, input bit c0e,
                        input bit c1v, input logic [7:0] c1id, input bit c1e,
                        input bit fl, input logic [7:0] fid, input bit tr);
        ev_t e;
        hd_t h;
        int  n;
        bit  cond;
        rst = r;
        i_alloc_vld = 4'((1 << na) - 1);
        i_alloc_base_id = next_alloc;
        i_alloc_ld = ldm;
        i_alloc_st = stm;
        i_cmt0_vld = c0v; i_cmt0_rob_id = c0id; i_cmt0_excp = c0e;
        i_cmt1_vld = c1v; i_cmt1_rob_id = c1id; i_cmt1_excp = c1e;
        i_flush = fl; i_flush_rob_id = fid; i_trap_flush = tr;

        e = '{default: 0};
        e.cyc = cyc + 1;
        e.base = mhead;
        if (r) begin
            rob.delete();
            mhead = 8'd0;
            next_alloc = 8'd0;
            prev_cond = 1'b0;
        end else begin
            n = 0;
            if (!tr) begin
                for (int k = 0; k < 4 && k < rob.size(); k++) begin
                    if (!rob[k].done || rob[k].excp) break;
                    if (fl && younger(rob[k].id, fid)) break;
                    e.ret[k] = 1'b1;
                    e.ld[k] = rob[k].ld;
                    e.st[k] = rob[k].st;
                    n++;
                end
            end
            cond = !tr && rob.size() > 0 && rob[0].done && rob[0].excp;
            e.excp = cond && !prev_cond;
            e.excp_id = mhead;
            prev_cond = cond;
            repeat (n) void'(rob.pop_front());
            mhead = mhead + 8'(n);
            foreach (rob[i]) begin
                if (c0v && rob[i].id == c0id) begin rob[i].done = 1'b1; rob[i].excp |= c0e; end
                if (c1v && rob[i].id == c1id) begin rob[i].done = 1'b1; rob[i].excp |= c1e; end
            end
            if (tr) begin
                rob.delete();
                next_alloc = mhead;
            end else if (fl) begin
                while (rob.size() > 0 && younger(rob[rob.size()-1].id, fid)) void'(rob.pop_back());
                next_alloc = fid + 8'd1;
            end else begin
                for (int k = 0; k < na; k++)
                    rob.push_back('{id: next_alloc + 8'(k), done: 1'b0, excp: 1'b0,
                                    ld: ldm[k], st: stm[k]});
                next_alloc = next_alloc + 8'(na);
            end
            if (e.ret != 4'd0 || e.excp) ev_q.push_back(e);
        end
        h.cyc = cyc + 1;
        h.head = mhead;
        hd_q.push_back(h);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(0, 0, 4'd0, 4'd0, 0, 8'd0, 0, 0, 8'd0, 0, 0, 8'd0, 0);
    endtask

    task automatic do_alloc(input int na, input logic [3:0] ldm, input logic [3:0] stm);
        step(0, na, ldm, stm, 0, 8'd0, 0, 0, 8'd0, 0, 0, 8'd0, 0);
    endtask

    task automatic do_cmt(input logic [7:0] a, input bit ae, input bit bv,
                          input logic [7:0] b, input bit be);
        step(0, 0, 4'd0, 4'd0, 1, a, ae, bv, b, be, 0, 8'd0, 0);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (hd_q.size() > 0 && hd_q[0].cyc == cyc) begin
                mh = hd_q.pop_front();
                check("head_id", o_head_id, mh.head);
            end
            if (ev_q.size() > 0 && ev_q[0].cyc == cyc) begin
                me = ev_q.pop_front();
                check("ret_vld", o_ret_vld, me.ret);
                if (me.ret != 4'd0) begin
                    check("ret_ld_vld", o_ret_ld_vld, me.ld);
                    check("ret_st_vld", o_ret_st_vld, me.st);
                    check("ret_base_id", o_ret_base_id, me.base);
                    check("s_ret", o_s_ret, |me.st);
                end
                check("excp_vld", o_excp_vld, me.excp);
                if (me.excp) check("excp_rob_id", o_excp_rob_id, me.excp_id);
            end else begin
                check("quiet_outputs", {o_ret_vld, o_ret_ld_vld, o_ret_st_vld, o_s_ret, o_excp_vld}, 0);
            end
        end
    end

    initial begin
        int         na, room;
        logic [3:0] ldm, stm;
        bit         c0v, c1v, c0e, c1e, fl, tr;
        logic [7:0] c0id, c1id, fid;

        mhead = 8'd0;
        next_alloc = 8'd0;
        prev_cond = 1'b0;
        step(1, 0, 4'd0, 4'd0, 0, 8'd0, 0, 0, 8'd0, 0, 0, 8'd0, 0);
        mon_en = 1'b1;
        check("rst_ret_vld", o_ret_vld, 0);
        check("rst_ld_st", {o_ret_ld_vld, o_ret_st_vld, o_s_ret}, 0);
        check("rst_excp", {o_excp_vld, o_excp_rob_id}, 0);
        check("rst_base_head", {o_ret_base_id, o_head_id}, 0);
        step(1, 0, 4'd0, 4'd0, 0, 8'd0, 0, 0, 8'd0, 0, 0, 8'd0, 0);

        // Completion with nothing allocated must not retire.
        do_cmt(8'd5, 0, 0, 8'd0, 0);
        idle();

        // Four-wide retire with ld/st lane masks.
        do_alloc(4, 4'b0001, 4'b1000);
        do_cmt(8'd3, 0, 1, 8'd2, 0);
        do_cmt(8'd1, 0, 1, 8'd0, 0);
        idle(); idle();

        // Out-of-order completion: nothing retires until the oldest is done.
        do_alloc(4, 4'b0000, 4'b0000);
        do_cmt(8'd5, 0, 1, 8'd6, 0);
        do_cmt(8'd7, 0, 0, 8'd0, 0);
        do_cmt(8'd4, 0, 0, 8'd0, 0);
        idle(); idle();

        // Exception stalls the head until a trap flush clears everything.
        do_alloc(4, 4'b0010, 4'b0100);
        do_cmt(8'd8, 0, 1, 8'd9, 0);
        do_cmt(8'd10, 1, 0, 8'd0, 0);
        idle(); idle(); idle();
        step(0, 0, 4'd0, 4'd0, 0, 8'd0, 0, 0, 8'd0, 0, 0, 8'd0, 1);
        idle();

        // Refill 10..19 and drain to head 20.
        do_alloc(4, 4'b0011, 4'b0000);
        do_alloc(4, 4'b0000, 4'b1100);
        do_alloc(2, 4'b0001, 4'b0010);
        for (int i = 10; i < 20; i += 2) do_cmt(8'(i), 0, 1, 8'(i + 1), 0);
        idle(); idle();

        // Partial flush keeps 20,21; 22,23 die; late completion to 22 is ignored.
        do_alloc(4, 4'b0101, 4'b1010);
        step(0, 0, 4'd0, 4'd0, 1, 8'd20, 0, 1, 8'd21, 0, 1, 8'd21, 0);
        idle();
        do_cmt(8'd22, 0, 0, 8'd0, 0);
        idle(); idle();

        // Walk the head up to 126 to exercise the index wrap.
        for (int g = 0; g < 400 && mhead != 8'd126; g++) begin
            room = 126 - int'(next_alloc);
            na = (room > 4) ? 4 : ((room < 0) ? 0 : room);
            c0v = 0; c1v = 0; c0id = 8'd0; c1id = 8'd0;
            foreach (rob[i]) begin
                if (!rob[i].done) begin
                    if (!c0v) begin c0v = 1; c0id = rob[i].id; end
                    else if (!c1v) begin c1v = 1; c1id = rob[i].id; end
                end
            end
            step(0, na, 4'b1001, 4'b0110, c0v, c0id, 0, c1v, c1id, 0, 0, 8'd0, 0);
        end
        do_alloc(4, 4'b0101, 4'b0010);
        do_cmt(8'd129, 0, 1, 8'd128, 0);
        do_cmt(8'd127, 0, 1, 8'd126, 0);
        idle(); idle();

        for (int t = 0; t < 3000; t++) begin
            fl = 0; tr = 0; fid = 8'd0;
            c0v = 0; c1v = 0; c0e = 0; c1e = 0; c0id = 8'd0; c1id = 8'd0;
            if (rob.size() > 0 && rob[0].done && rob[0].excp) begin
                if ($urandom_range(0, 2) == 0) tr = 1;
            end else if ($urandom_range(0, 99) == 0) begin
                tr = 1;
            end else if (rob.size() > 0 && $urandom_range(0, 39) == 0) begin
                fl = 1;
                fid = rob[$urandom_range(0, rob.size() - 1)].id;
            end
            na = $urandom_range(0, 4);
            if (rob.size() + na > 120) na = 0;
            ldm = 4'($urandom);
            stm = 4'($urandom) & ~ldm;
            if (rob.size() > 0 && $urandom_range(0, 3) != 0) begin
                c0v = 1;
                c0id = rob[$urandom_range(0, rob.size() - 1)].id;
                c0e = ($urandom_range(0, 29) == 0);
            end
            if (rob.size() > 0 && $urandom_range(0, 3) != 0) begin
                c1v = 1;
                c1id = ($urandom_range(0, 7) == 0 && c0v) ? c0id
                       : rob[$urandom_range(0, rob.size() - 1)].id;
                c1e = ($urandom_range(0, 29) == 0);
            end
            step(0, na, ldm, stm, c0v, c0id, c0e, c1v, c1id, c1e, fl, fid, tr);
        end

        // Reset in the middle of traffic drops in-flight completions.
        c0id = (rob.size() > 0) ? rob[0].id : 8'd0;
        step(1, 0, 4'd0, 4'd0, rob.size() > 0, c0id, 0, 0, 8'd0, 0, 0, 8'd0, 0);
        idle(); idle();
        do_alloc(2, 4'b0010, 4'b0001);
        do_cmt(8'd1, 0, 1, 8'd0, 0);
        idle(); idle();

        @(negedge clk);
        #1;
        check("leftover_events", ev_q.size(), 0);
        check("leftover_heads", hd_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
